// File: rtl/pause_pkg.sv
// Shared types and sizing helpers for the pause / fade controller.
package pause_pkg;

  // Controller states: running, waiting for vblank, halted, fading, fully dimmed.
  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PENDING = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_FADING  = 3'd3,
    ST_DIMMED  = 3'd4
  } pause_state_t;

  // The ms counter covers both the dim delay and the fade step interval,
  // so it is sized for the larger of the two.
  function automatic int ms_cnt_width(input int dim_ms, input int fade_ms);
    int m;
    m = (dim_ms > fade_ms) ? dim_ms : fade_ms;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/dim_shift.sv
// Single colour channel dimmer: logical right shift, no state.
module dim_shift #(
  parameter int W  = 8,
  parameter int SW = 2
) (
  input  logic [W-1:0]  i_din,
  input  logic [SW-1:0] i_shift,
  output logic [W-1:0]  o_dout
);

  // Zero fill from the top; each channel is shifted in isolation.
  assign o_dout = i_din >> i_shift;

endmodule

// File: rtl/pause_fade_ctrl.sv
// Pause controller: button / requester / OSD pause with optional timed screen dimming.
module pause_fade_ctrl
  import pause_pkg::*;
#(
  parameter int RW          = 8,
  parameter int GW          = 8,
  parameter int BW          = 8,
  parameter int NREQ        = 1,
  parameter int TICK_DIV    = 24000,
  parameter int DIM_MS      = 10000,
  parameter int FADE_MS     = 250,
  parameter int MAX_SHIFT   = 2,
  parameter int VSYNC_ENTRY = 1,
  localparam int DLW        = (MAX_SHIFT > 0) ? $clog2(MAX_SHIFT + 1) : 1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  user_button,
  input  logic [NREQ-1:0]       pause_request,
  input  logic                  OSD_STATUS,
  input  logic [1:0]            options,
  input  logic                  vblank,
  input  logic [RW+GW+BW-1:0]   rgb_in,
  output logic [RW+GW+BW-1:0]   rgb_out,
  output logic                  pause_cpu,
  output logic [DLW-1:0]        dim_level
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_W   = ms_cnt_width(DIM_MS, FADE_MS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]   DIM_LAST  = MS_W'(DIM_MS - 1);
  localparam logic [MS_W-1:0]   FADE_LAST = MS_W'(FADE_MS - 1);

  pause_state_t          r_state;
  pause_state_t          w_state_next;
  logic                  r_btn_prev;
  logic                  r_btn_armed;
  logic                  r_user_pause;
  logic                  r_vblank_prev;
  logic                  r_pause_cpu;
  logic [TICK_W-1:0]     r_tick_cnt;
  logic [TICK_W-1:0]     w_tick_next;
  logic [MS_W-1:0]       r_ms_cnt;
  logic [MS_W-1:0]       w_ms_next;
  logic [DLW-1:0]        r_dim_level;
  logic [DLW-1:0]        w_dim_next;
  logic [DLW-1:0]        w_dim_inc;
  logic [RW+GW+BW-1:0]   r_rgb;
  logic [RW-1:0]         w_r_dim;
  logic [GW-1:0]         w_g_dim;
  logic [BW-1:0]         w_b_dim;
  logic                  w_btn_rise;
  logic                  w_user_pause_next;
  logic                  w_req;
  logic                  w_eligible;
  logic                  w_dim_ok;
  logic                  w_vb_edge;
  logic                  w_run_timer;
  logic                  w_tick;

  // The armed flag swallows the first sample after reset so a button held
  // through reset release is taken as history, not as a fresh press.
  assign w_btn_rise        = user_button & ~r_btn_prev & r_btn_armed;
  // Requests see the pause toggle in the same cycle the press is sampled.
  assign w_user_pause_next = r_user_pause ^ w_btn_rise;
  assign w_req       = w_user_pause_next | (|pause_request) | (OSD_STATUS & options[0]);
  assign w_eligible  = w_user_pause_next | (OSD_STATUS & options[0]);
  assign w_dim_ok    = w_eligible & options[1];
  assign w_vb_edge   = vblank & ~r_vblank_prev;
  assign w_run_timer = ((r_state == ST_PAUSED) || (r_state == ST_FADING)) && w_dim_ok;
  assign w_tick      = w_run_timer && (r_tick_cnt == TICK_LAST);
  assign w_dim_inc   = r_dim_level + DLW'(1);

  // Next-state, prescaler and dim-level logic.
  always_comb begin
    w_state_next = r_state;
    w_dim_next   = r_dim_level;
    w_ms_next    = w_run_timer ? r_ms_cnt : '0;
    w_tick_next  = '0;
    if (w_run_timer) begin
      w_tick_next = w_tick ? '0 : r_tick_cnt + TICK_W'(1);
    end
    case (r_state)
      ST_RUN: begin
        if (w_req) begin
          w_state_next = (VSYNC_ENTRY != 0) ? ST_PENDING : ST_PAUSED;
        end
      end
      ST_PENDING: begin
        if (!w_req) begin
          w_state_next = ST_RUN;
        end else if (w_vb_edge) begin
          w_state_next = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (!w_req) begin
          w_state_next = ST_RUN;
        end else if (w_tick) begin
          if (r_ms_cnt == DIM_LAST) begin
            // With no shift range the counter just saturates here.
            if (MAX_SHIFT > 0) begin
              w_ms_next    = '0;
              w_dim_next   = DLW'(1);
              w_state_next = (MAX_SHIFT == 1) ? ST_DIMMED : ST_FADING;
            end
          end else begin
            w_ms_next = r_ms_cnt + MS_W'(1);
          end
        end
      end
      ST_FADING: begin
        if (!w_req) begin
          w_state_next = ST_RUN;
        end else if (!w_dim_ok) begin
          w_state_next = ST_PAUSED;
        end else if (w_tick) begin
          if (r_ms_cnt == FADE_LAST) begin
            w_ms_next  = '0;
            w_dim_next = w_dim_inc;
            if (w_dim_inc == DLW'(MAX_SHIFT)) begin
              w_state_next = ST_DIMMED;
            end
          end else begin
            w_ms_next = r_ms_cnt + MS_W'(1);
          end
        end
      end
      ST_DIMMED: begin
        if (!w_req) begin
          w_state_next = ST_RUN;
        end else if (!w_dim_ok) begin
          w_state_next = ST_PAUSED;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
    // Only the fading states carry a non-zero shift.
    if ((w_state_next == ST_RUN) || (w_state_next == ST_PENDING) ||
        (w_state_next == ST_PAUSED)) begin
      w_dim_next = '0;
    end
  end

  // Button, vblank history and user pause toggle.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_btn_prev    <= 1'b0;
      r_btn_armed   <= 1'b0;
      r_user_pause  <= 1'b0;
      r_vblank_prev <= 1'b0;
    end else begin
      r_btn_prev    <= user_button;
      r_btn_armed   <= 1'b1;
      r_user_pause  <= w_user_pause_next;
      r_vblank_prev <= vblank;
    end
  end

  // State, counters and the registered halt output.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_tick_cnt  <= '0;
      r_ms_cnt    <= '0;
      r_dim_level <= '0;
      r_pause_cpu <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_tick_cnt  <= w_tick_next;
      r_ms_cnt    <= w_ms_next;
      r_dim_level <= w_dim_next;
      r_pause_cpu <= (w_state_next == ST_PAUSED) || (w_state_next == ST_FADING) ||
                     (w_state_next == ST_DIMMED);
    end
  end

  dim_shift #(.W(RW), .SW(DLW)) u_dim_r (
    .i_din   (rgb_in[RW+GW+BW-1:GW+BW]),
    .i_shift (r_dim_level),
    .o_dout  (w_r_dim)
  );

  dim_shift #(.W(GW), .SW(DLW)) u_dim_g (
    .i_din   (rgb_in[GW+BW-1:BW]),
    .i_shift (r_dim_level),
    .o_dout  (w_g_dim)
  );

  dim_shift #(.W(BW), .SW(DLW)) u_dim_b (
    .i_din   (rgb_in[BW-1:0]),
    .i_shift (r_dim_level),
    .o_dout  (w_b_dim)
  );

  // Pixel output register: one cycle of latency behind rgb_in.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= {w_r_dim, w_g_dim, w_b_dim};
    end
  end

  assign rgb_out   = r_rgb;
  assign pause_cpu = r_pause_cpu;
  assign dim_level = r_dim_level;

endmodule

// File: tb/tb_pause_fade_ctrl.sv
// Directed bench for pause_fade_ctrl with a fast tick configuration.
module tb_pause_fade_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        user_button;
  logic [0:0]  pause_request;
  logic        OSD_STATUS;
  logic [1:0]  options;
  logic        vblank;
  logic [23:0] rgb_in;
  logic [23:0] rgb_out;
  logic        pause_cpu;
  logic [1:0]  dim_level;

  int checks = 0;
  int errors = 0;

  pause_fade_ctrl #(
    .RW(8), .GW(8), .BW(8), .NREQ(1),
    .TICK_DIV(4), .DIM_MS(3), .FADE_MS(2), .MAX_SHIFT(2), .VSYNC_ENTRY(1)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .user_button   (user_button),
    .pause_request (pause_request),
    .OSD_STATUS    (OSD_STATUS),
    .options       (options),
    .vblank        (vblank),
    .rgb_in        (rgb_in),
    .rgb_out       (rgb_out),
    .pause_cpu     (pause_cpu),
    .dim_level     (dim_level)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL reset_pause_cpu: got %b want 0", pause_cpu); end
    checks++;
    if (dim_level !== 2'd0) begin errors++; $display("FAIL reset_dim_level: got %0d want 0", dim_level); end
    checks++;
    if (rgb_out !== 24'h000000) begin errors++; $display("FAIL reset_rgb_out: got %h want 000000", rgb_out); end
    reset = 1'b0;
    cyc();
    $display("test_reset done");
  endtask

  task automatic test_run_passthrough();
    rgb_in = 24'h123456;
    cyc();
    checks++;
    if (rgb_out !== 24'h123456) begin errors++; $display("FAIL run_rgb: got %h want 123456", rgb_out); end
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL run_pause_cpu: got %b want 0", pause_cpu); end
    $display("test_run_passthrough done");
  endtask

  // Button pause, vblank entry, timed fade to full dim.
  task automatic test_user_fade();
    options = 2'b10;
    rgb_in  = 24'hFFFFFF;
    user_button = 1'b1;
    cyc();
    user_button = 1'b0;
    repeat (3) cyc();
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL pending_no_halt: got %b want 0", pause_cpu); end
    vblank = 1'b1;             // vblank edge cycle (call it 20)
    cyc();                     // cycle 21
    vblank = 1'b0;
    checks++;
    if (pause_cpu !== 1'b1) begin errors++; $display("FAIL entry_halt: got %b want 1", pause_cpu); end
    repeat (11) cyc();         // cycle 32
    checks++;
    if (dim_level !== 2'd0) begin errors++; $display("FAIL dim_before_delay: got %0d want 0", dim_level); end
    cyc();                     // cycle 33
    checks++;
    if (dim_level !== 2'd1) begin errors++; $display("FAIL dim_step1: got %0d want 1", dim_level); end
    rgb_in = 24'h80FF01;
    cyc();                     // cycle 34
    checks++;
    if (rgb_out !== 24'h407F00) begin errors++; $display("FAIL rgb_shift1: got %h want 407f00", rgb_out); end
    rgb_in = 24'hFFFFFF;
    repeat (6) cyc();          // cycle 40
    checks++;
    if (dim_level !== 2'd1) begin errors++; $display("FAIL dim_before_step2: got %0d want 1", dim_level); end
    cyc();                     // cycle 41
    checks++;
    if (dim_level !== 2'd2) begin errors++; $display("FAIL dim_step2: got %0d want 2", dim_level); end
    cyc();                     // cycle 42
    checks++;
    if (rgb_out !== 24'h3F3F3F) begin errors++; $display("FAIL rgb_shift2: got %h want 3f3f3f", rgb_out); end
    repeat (30) cyc();
    checks++;
    if (dim_level !== 2'd2) begin errors++; $display("FAIL dim_saturate: got %0d want 2", dim_level); end
    checks++;
    if (pause_cpu !== 1'b1) begin errors++; $display("FAIL dimmed_halt: got %b want 1", pause_cpu); end
    $display("test_user_fade done");
  endtask

  // Second press while fully dimmed releases everything.
  task automatic test_dimmed_exit();
    rgb_in = 24'hA5C3F0;
    user_button = 1'b1;
    cyc();
    user_button = 1'b0;
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL exit_halt: got %b want 0", pause_cpu); end
    checks++;
    if (dim_level !== 2'd0) begin errors++; $display("FAIL exit_dim: got %0d want 0", dim_level); end
    checks++;
    if (rgb_out !== 24'h29303C) begin errors++; $display("FAIL exit_rgb_lag: got %h want 29303c", rgb_out); end
    cyc();
    checks++;
    if (rgb_out !== 24'hA5C3F0) begin errors++; $display("FAIL exit_rgb: got %h want a5c3f0", rgb_out); end
    $display("test_dimmed_exit done");
  endtask

  // External requester halts the CPU but never dims.
  task automatic test_request_only();
    int bad;
    options = 2'b10;
    pause_request = 1'b1;
    repeat (2) cyc();
    vblank = 1'b1;
    cyc();
    vblank = 1'b0;
    checks++;
    if (pause_cpu !== 1'b1) begin errors++; $display("FAIL req_halt: got %b want 1", pause_cpu); end
    bad = 0;
    for (int i = 0; i < 420; i++) begin
      cyc();
      if (dim_level !== 2'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL req_no_dim: got %0d dimmed cycles want 0", bad); end
    pause_request = 1'b0;
    cyc();
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL req_release: got %b want 0", pause_cpu); end
    $display("test_request_only done");
  endtask

  // OSD pause honours options[0]; options[1] clear means no dimming.
  task automatic test_osd();
    int bad;
    OSD_STATUS = 1'b1;
    options = 2'b01;
    cyc();
    vblank = 1'b1;
    cyc();
    vblank = 1'b0;
    checks++;
    if (pause_cpu !== 1'b1) begin errors++; $display("FAIL osd_halt: got %b want 1", pause_cpu); end
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (dim_level !== 2'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL osd_no_dim: got %0d dimmed cycles want 0", bad); end
    options = 2'b00;
    cyc();
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL osd_disable_release: got %b want 0", pause_cpu); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      vblank = ((i % 5) == 2);
      cyc();
      if (pause_cpu !== 1'b0) bad++;
    end
    vblank = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL osd_disabled_halt: got %0d halted cycles want 0", bad); end
    OSD_STATUS = 1'b0;
    cyc();
    $display("test_osd done");
  endtask

  // Request dropping on the vblank edge cycle aborts entry.
  task automatic test_pending_abort();
    int bad;
    pause_request = 1'b1;
    cyc();
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL abort_pending: got %b want 0", pause_cpu); end
    pause_request = 1'b0;
    vblank = 1'b1;
    cyc();
    vblank = 1'b0;
    bad = (pause_cpu !== 1'b0) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (pause_cpu !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL abort_halt: got %0d halted cycles want 0", bad); end
    pause_request = 1'b1;
    repeat (5) cyc();
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL wait_vblank: got %b want 0", pause_cpu); end
    vblank = 1'b1;
    cyc();
    vblank = 1'b0;
    checks++;
    if (pause_cpu !== 1'b1) begin errors++; $display("FAIL late_entry: got %b want 1", pause_cpu); end
    pause_request = 1'b0;
    repeat (2) cyc();
    $display("test_pending_abort done");
  endtask

  // Asynchronous reset mid-fade with the button held.
  task automatic test_reset_mid_fade();
    int bad;
    options = 2'b10;
    rgb_in  = 24'hFFFFFF;
    user_button = 1'b1;
    cyc();
    user_button = 1'b0;
    cyc();
    vblank = 1'b1;
    cyc();
    vblank = 1'b0;
    repeat (14) cyc();
    checks++;
    if (dim_level !== 2'd1) begin errors++; $display("FAIL prefade_dim: got %0d want 1", dim_level); end
    #2;
    reset = 1'b1;
    user_button = 1'b1;
    #1;
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL async_halt: got %b want 0", pause_cpu); end
    checks++;
    if (dim_level !== 2'd0) begin errors++; $display("FAIL async_dim: got %0d want 0", dim_level); end
    checks++;
    if (rgb_out !== 24'h000000) begin errors++; $display("FAIL async_rgb: got %h want 000000", rgb_out); end
    repeat (2) cyc();
    reset = 1'b0;
    repeat (3) cyc();
    vblank = 1'b1;
    cyc();
    vblank = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (pause_cpu !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL held_button_toggle: got %0d halted cycles want 0", bad); end
    user_button = 1'b0;
    cyc();
    user_button = 1'b1;
    cyc();
    user_button = 1'b0;
    vblank = 1'b1;
    cyc();
    vblank = 1'b0;
    checks++;
    if (pause_cpu !== 1'b1) begin errors++; $display("FAIL repress_halt: got %b want 1", pause_cpu); end
    user_button = 1'b1;
    cyc();
    user_button = 1'b0;
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL repress_release: got %b want 0", pause_cpu); end
    $display("test_reset_mid_fade done");
  endtask

  initial begin
    reset = 1'b1;
    user_button = 1'b0;
    pause_request = 1'b0;
    OSD_STATUS = 1'b0;
    options = 2'b00;
    vblank = 1'b0;
    rgb_in = 24'h000000;
    test_reset();
    test_run_passthrough();
    test_user_fade();
    test_dimmed_exit();
    test_request_only();
    test_osd();
    test_pending_abort();
    test_reset_mid_fade();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pause_fade_ctrl.md
PAUSE_FADE_CTRL -- requirements
Module: pause_fade_ctrl

Interface
REQ-001 Parameter RW, default 8, meaning red channel width in bits.
REQ-002 Parameter GW, default 8, meaning green channel width in bits.
REQ-003 Parameter BW, default 8, meaning blue channel width in bits.
REQ-004 Parameter NREQ, default 1, meaning number of external pause requesters (e.g. hiscore).
REQ-005 Parameter TICK_DIV, default 24000, meaning clk_sys cycles per 1 ms tick.
REQ-006 Parameter DIM_MS, default 10000, meaning ms of eligible pause before fade starts.
REQ-007 Parameter FADE_MS, default 250, meaning ms between fade steps.
REQ-008 Parameter MAX_SHIFT, default 2, meaning final right-shift applied to each colour channel when fully dimmed.
REQ-009 Parameter VSYNC_ENTRY, default 1, meaning 1 defers pause entry to vblank rising edge, 0 enters immediately.
REQ-010 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-011 reset  in  1  asynchronous, active-high reset.
REQ-012 user_button  in  1  joystick pause button, level.
REQ-013 pause_request  in  NREQ  per-source pause requests, level.
REQ-014 OSD_STATUS  in  1  OSD open.
REQ-015 options  in  2  [0]=pause when OSD open enable, [1]=dim enable.
REQ-016 vblank  in  1  video vertical blank.
REQ-017 rgb_in  in  RW+GW+BW  pixel {r,g,b}.
REQ-018 rgb_out  out  RW+GW+BW  pixel after dimming.
REQ-019 pause_cpu  out  1  CPU halt.
REQ-020 dim_level  out  clog2(MAX_SHIFT+1)  current shift amount.

Function
REQ-021 user_button rising edge (registered compare against previous sample) SHALL toggle user_pause; held level SHALL not retoggle.
REQ-022 Request req SHALL be user_pause | OR(pause_request) | (OSD_STATUS & options[0]); eligible SHALL be user_pause | (OSD_STATUS & options[0]).
REQ-023 FSM states RUN, PENDING, PAUSED, FADING, DIMMED.
REQ-024 RUN: req=1 -> PENDING if VSYNC_ENTRY=1, else PAUSED; pause_cpu=0.
REQ-025 PENDING: pause_cpu=0; vblank rising edge -> PAUSED; req=0 -> RUN; simultaneous req=0 and edge -> RUN.
REQ-026 PAUSED/FADING/DIMMED: pause_cpu=1, asserted the cycle after state entry; req=0 -> RUN same cycle regardless of counters, pause_cpu=0 next cycle.
REQ-027 Tick prescaler SHALL run only in PAUSED/FADING with eligible=1 and options[1]=1; otherwise it and the ms counter SHALL clear.
REQ-028 PAUSED: ms counter reaching DIM_MS-1 on a tick -> FADING, dim_level+1, ms counter cleared.
REQ-029 FADING: every FADE_MS ticks dim_level+1; reaching MAX_SHIFT -> DIMMED; dim_level SHALL never exceed MAX_SHIFT.
REQ-030 Loss of eligibility or options[1]=0 in FADING/DIMMED -> PAUSED with dim_level=0 next cycle.
REQ-031 dim_level SHALL be 0 in RUN and PENDING.
REQ-032 rgb_out SHALL be each channel logically right-shifted by dim_level, registered, latency 1 cycle, channels independent, no carry between fields.
REQ-033 MAX_SHIFT=0 SHALL disable fading (PAUSED never leaves except to RUN).

Reset
REQ-034 Reset SHALL force state RUN, user_pause=0, counters=0, dim_level=0, pause_cpu=0, rgb_out=0, button history=0.
REQ-035 Reset asserted mid-pause or mid-fade SHALL release pause_cpu asynchronously; a button held across reset release SHALL not toggle.

Structure
REQ-036 State enum and ms counter width function SHALL live in shared package pause_pkg.
REQ-037 Per-channel shifter SHALL be sub-module dim_shift, parametrised by width, instantiated three times.

Verification
REQ-038 TICK_DIV=4, DIM_MS=3, FADE_MS=2, MAX_SHIFT=2: button pulse, vblank edge at cycle 20 -> pause_cpu=1 at cycle 21, dim_level 1 at +12 cycles, 2 at +20, rgb_in 0xFFFFFF -> rgb_out 0x3F3F3F.
REQ-039 pause_request[0]=1 only -> pause_cpu=1 after vblank edge, dim_level stays 0 for 100 ticks.
REQ-040 OSD_STATUS=1, options=2'b01 -> pause, no dim; options=2'b00 -> pause_cpu never asserts.
REQ-041 DIMMED, second button pulse -> RUN, pause_cpu=0 and dim_level=0 next cycle, rgb_out equals rgb_in one cycle later.
REQ-042 PENDING, req drops same cycle as vblank rising -> RUN, pause_cpu stays 0.
REQ-043 Reset asserted during FADING with button held -> all outputs 0 immediately; after release, no toggle until button released and re-pressed.
